training_sequencer: RTL and testbench

//  Top-level training scheduler. Per sample it runs the forward pass layer by layer
//  (layer 0..LAYER_MAX-1), then backpropagation top-down (LAYER_MAX-1..0),

---
 rtl/training_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_training_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/training_sequencer.sv
// Training scheduler: per sample, forward layers 0..LAYER_MAX-1, then backprop top-down, for N epochs.
// Optional per-phase watchdog enabled by defining TRAIN_WATCHDOG_EN.
module training_sequencer #(
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int LAYER_MAX        = 3,
  parameter int SAMPLE_ADDR_SIZE = 10,
  parameter int SAMPLE_COUNT     = 1000,
  parameter int EPOCH_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        abort,
  input  logic [EPOCH_WIDTH-1:0]      epochs,
  output logic                        fwd_start,
  output logic [LAYER_ADDR_WIDTH-1:0] fwd_layer,
  output logic [SAMPLE_ADDR_SIZE-1:0] fwd_sample,
  input  logic                        fwd_valid,
  output logic                        bp_start,
  output logic [LAYER_ADDR_WIDTH-1:0] bp_layer,
  output logic [SAMPLE_ADDR_SIZE-1:0] bp_sample,
  input  logic                        bp_valid,
  input  logic                        bp_error,
  output logic                        busy,
  output logic                        done,
  output logic                        fault,
  output logic [EPOCH_WIDTH-1:0]      epoch_cnt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FWD_GO   = 3'd1;
  localparam logic [2:0] FWD_WAIT = 3'd2;
  localparam logic [2:0] BP_GO    = 3'd3;
  localparam logic [2:0] BP_WAIT  = 3'd4;
  localparam logic [2:0] NEXT     = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;
  localparam logic [2:0] FAULT    = 3'd7;

  localparam logic [LAYER_ADDR_WIDTH-1:0] LAST_LAYER  = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
  localparam logic [SAMPLE_ADDR_SIZE-1:0] LAST_SAMPLE = SAMPLE_ADDR_SIZE'(SAMPLE_COUNT - 1);

  logic [2:0]                  state;
  logic [LAYER_ADDR_WIDTH-1:0] layer;
  logic [SAMPLE_ADDR_SIZE-1:0] sample;
  logic [EPOCH_WIDTH-1:0]      epochs_lat;
  logic                        abort_req;
  logic                        wd_expired;

  assign fwd_layer  = layer;
  assign bp_layer   = layer;
  assign fwd_sample = sample;
  assign bp_sample  = sample;
  assign busy       = (state != IDLE) && (state != DONE) && (state != FAULT);

`ifdef TRAIN_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Every WAIT state is entered from a GO state, so the count restarts at zero per phase.
  always_ff @(posedge clk) begin
    if (rst)
      wd_cnt <= '0;
    else if (state == FWD_WAIT || state == BP_WAIT)
      wd_cnt <= wd_cnt + WD_W'(1);
    else
      wd_cnt <= '0;
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      layer      <= '0;
      sample     <= '0;
      epochs_lat <= '0;
      epoch_cnt  <= '0;
      abort_req  <= 1'b0;
      fwd_start  <= 1'b0;
      bp_start   <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      fwd_start <= 1'b0;
      bp_start  <= 1'b0;
      done      <= 1'b0;
      if (abort && busy)
        abort_req <= 1'b1;

      case (state)
        IDLE, FAULT: begin
          if (run) begin
            epochs_lat <= epochs;
            fault      <= 1'b0;
            epoch_cnt  <= '0;
            sample     <= '0;
            layer      <= '0;
            abort_req  <= 1'b0;
            state      <= (epochs == '0) ? DONE : FWD_GO;
          end
        end

        // Abort is only honoured here, so a layer that has started always completes.
        FWD_GO: begin
          if (abort_req || abort) begin
            state <= DONE;
          end else begin
            fwd_start <= 1'b1;
            state     <= FWD_WAIT;
          end
        end

        FWD_WAIT: begin
          if (fwd_valid) begin
            if (layer == LAST_LAYER) begin
              state <= BP_GO;
            end else begin
              layer <= layer + LAYER_ADDR_WIDTH'(1);
              state <= FWD_GO;
            end
          end else if (wd_expired) begin
            fault <= 1'b1;
            state <= FAULT;
          end
        end

        BP_GO: begin
          if (abort_req || abort) begin
            state <= DONE;
          end else begin
            bp_start <= 1'b1;
            state    <= BP_WAIT;
          end
        end

        BP_WAIT: begin
          if (bp_error) begin
            fault <= 1'b1;
            state <= FAULT;
          end else if (bp_valid) begin
            if (layer == '0) begin
              state <= NEXT;
            end else begin
              layer <= layer - LAYER_ADDR_WIDTH'(1);
              state <= BP_GO;
            end
          end else if (wd_expired) begin
            fault <= 1'b1;
            state <= FAULT;
          end
        end

        // Sample wrap closes an epoch; the epoch limit is only tested at that point.
        NEXT: begin
          layer <= '0;
          if (sample == LAST_SAMPLE) begin
            sample    <= '0;
            epoch_cnt <= epoch_cnt + EPOCH_WIDTH'(1);
            if (epoch_cnt + EPOCH_WIDTH'(1) == epochs_lat)
              state <= DONE;
            else
              state <= FWD_GO;
          end else begin
            sample <= sample + SAMPLE_ADDR_SIZE'(1);
            state  <= FWD_GO;
          end
        end

        DONE: begin
          done      <= 1'b1;
          abort_req <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_training_sequencer.sv
// Scoreboard bench for training_sequencer (LAYER_MAX=3, SAMPLE_COUNT=2, TIMEOUT_CYCLES=16).
module tb_training_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] epochs = '0;
  logic        fwd_start;
  logic [1:0]  fwd_layer;
  logic [9:0]  fwd_sample;
  logic        fwd_valid = 1'b0;
  logic        bp_start;
  logic [1:0]  bp_layer;
  logic [9:0]  bp_sample;
  logic        bp_valid = 1'b0;
  logic        bp_error = 1'b0;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] epoch_cnt;

  int vectors = 0;
  int miscompares = 0;
  int fwd_starts = 0;
  int bp_starts = 0;
  int dones = 0;

  typedef struct packed {
    bit       bp;
    bit [1:0] layer;
    bit [9:0] sample;
  } exp_t;

  exp_t exp_q[$];

  training_sequencer #(
    .LAYER_ADDR_WIDTH(2),
    .LAYER_MAX(3),
    .SAMPLE_ADDR_SIZE(10),
    .SAMPLE_COUNT(2),
    .EPOCH_WIDTH(16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort), .epochs(epochs),
    .fwd_start(fwd_start), .fwd_layer(fwd_layer), .fwd_sample(fwd_sample), .fwd_valid(fwd_valid),
    .bp_start(bp_start), .bp_layer(bp_layer), .bp_sample(bp_sample), .bp_valid(bp_valid),
    .bp_error(bp_error), .busy(busy), .done(done), .fault(fault), .epoch_cnt(epoch_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fwd_start) fwd_starts++;
    if (bp_start) bp_starts++;
    if (done) dones++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; abort = 1'b0; fwd_valid = 1'b0; bp_valid = 1'b0; bp_error = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] n);
    epochs = n;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_start(input int limit, output bit got, output bit is_bp);
    int i = 0;
    got = 1'b0;
    is_bp = 1'b0;
    while (!got && i < limit) begin
      @(negedge clk);
      if (fwd_start || bp_start) begin
        got = 1'b1;
        is_bp = bp_start;
      end
      i++;
    end
  endtask

  task automatic pulse_valid(input int delay, input bit is_bp);
    repeat (delay) @(negedge clk);
    if (is_bp) bp_valid = 1'b1; else fwd_valid = 1'b1;
    @(negedge clk);
    bp_valid = 1'b0;
    fwd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({busy, done, fault, fwd_start, bp_start} !== 5'b0) begin
      $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, fault, fwd_start, bp_start});
      miscompares++;
    end
    vectors++;
    if (epoch_cnt !== 16'd0 || fwd_layer !== 2'd0 || fwd_sample !== 10'd0) begin
      $display("[TB] FAIL reset_counters: got epoch %0d layer %0d sample %0d expected 0 0 0",
               epoch_cnt, fwd_layer, fwd_sample);
      miscompares++;
    end
  endtask

  task automatic test_full_epoch();
    bit got, is_bp;
    exp_t e;
    int n;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int l = 0; l < 3; l++) exp_q.push_back('{bp: 1'b0, layer: 2'(l), sample: 10'(s)});
      for (int l = 2; l >= 0; l--) exp_q.push_back('{bp: 1'b1, layer: 2'(l), sample: 10'(s)});
    end
    start_run(16'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_start(20, got, is_bp);
      vectors++;
      if (!got) begin
        $display("[TB] FAIL seq_start_timeout: got no start expected %s layer %0d", e.bp ? "bp" : "fwd", e.layer);
        miscompares++;
        exp_q.delete();
      end else begin
        vectors++;
        if ({is_bp, (is_bp ? bp_layer : fwd_layer), fwd_sample, bp_sample} !== {e.bp, e.layer, e.sample, e.sample}) begin
          $display("[TB] FAIL seq_start: got bp=%0d layer %0d sample %0d/%0d expected bp=%0d layer %0d sample %0d",
                   is_bp, is_bp ? bp_layer : fwd_layer, fwd_sample, bp_sample, e.bp, e.layer, e.sample);
          miscompares++;
        end
        @(negedge clk);
        vectors++;
        if ({fwd_start, bp_start} !== 2'b00 || (is_bp ? bp_layer : fwd_layer) !== e.layer) begin
          $display("[TB] FAIL seq_pulse_width: got starts %b layer %0d expected 00 layer %0d",
                   {fwd_start, bp_start}, is_bp ? bp_layer : fwd_layer, e.layer);
          miscompares++;
        end
        pulse_valid(1, is_bp);
      end
    end
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done !== 1'b1 || epoch_cnt !== 16'd1) begin
      $display("[TB] FAIL epoch_done: got done %b epoch_cnt %0d expected 1 1", done, epoch_cnt);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00) begin
      $display("[TB] FAIL epoch_idle: got done/busy %b expected 00", {done, busy});
      miscompares++;
    end
  endtask

  task automatic test_zero_epochs();
    int f0, b0;
    do_reset();
    f0 = fwd_starts; b0 = bp_starts;
    start_run(16'd0);
    vectors++;
    if (done !== 1'b0) begin
      $display("[TB] FAIL zero_done_early: got %b expected 0", done);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      $display("[TB] FAIL zero_done: got %b expected 1", done);
      miscompares++;
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (fwd_starts - f0 + bp_starts - b0 !== 0 || epoch_cnt !== 16'd0) begin
      $display("[TB] FAIL zero_no_starts: got starts %0d epoch %0d expected 0 0",
               fwd_starts - f0 + bp_starts - b0, epoch_cnt);
      miscompares++;
    end
  endtask

  task automatic test_bp_error();
    bit got, is_bp;
    int s0, d0;
    do_reset();
    start_run(16'd1);
    for (int k = 0; k < 4; k++) begin
      wait_start(20, got, is_bp);
      pulse_valid(2, is_bp);
    end
    wait_start(20, got, is_bp);
    vectors++;
    if (!got || is_bp !== 1'b1 || bp_layer !== 2'd1) begin
      $display("[TB] FAIL err_bp1_start: got start %0d bp %0d layer %0d expected 1 1 1", got, is_bp, bp_layer);
      miscompares++;
    end
    bp_error = 1'b1;
    @(negedge clk);
    bp_error = 1'b0;
    vectors++;
    if ({fault, busy} !== 2'b10) begin
      $display("[TB] FAIL err_fault: got fault/busy %b expected 10", {fault, busy});
      miscompares++;
    end
    s0 = fwd_starts + bp_starts;
    d0 = dones;
    repeat (20) @(negedge clk);
    vectors++;
    if (fwd_starts + bp_starts - s0 !== 0 || dones - d0 !== 0 || fault !== 1'b1) begin
      $display("[TB] FAIL err_sticky: got starts %0d dones %0d fault %b expected 0 0 1",
               fwd_starts + bp_starts - s0, dones - d0, fault);
      miscompares++;
    end
    start_run(16'd0);
    vectors++;
    if (fault !== 1'b0) begin
      $display("[TB] FAIL err_clear: got fault %b expected 0", fault);
      miscompares++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    bit got, is_bp;
    int s0, d0;
    do_reset();
    start_run(16'd1);
    wait_start(20, got, is_bp);
    pulse_valid(2, is_bp);
    wait_start(20, got, is_bp);
    vectors++;
    if (!got || is_bp !== 1'b0 || fwd_layer !== 2'd1) begin
      $display("[TB] FAIL abort_fwd1_start: got start %0d bp %0d layer %0d expected 1 0 1", got, is_bp, fwd_layer);
      miscompares++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    s0 = fwd_starts + bp_starts;
    d0 = dones;
    pulse_valid(1, 1'b0);
    repeat (10) @(negedge clk);
    vectors++;
    if (fwd_starts + bp_starts - s0 !== 0 || dones - d0 !== 1) begin
      $display("[TB] FAIL abort_done: got starts %0d dones %0d expected 0 1", fwd_starts + bp_starts - s0, dones - d0);
      miscompares++;
    end
    vectors++;
    if ({busy, fault} !== 2'b00 || epoch_cnt !== 16'd0) begin
      $display("[TB] FAIL abort_state: got busy/fault %b epoch %0d expected 00 0", {busy, fault}, epoch_cnt);
      miscompares++;
    end
  endtask

  task automatic test_stray();
    bit got, is_bp;
    int s0, d0, n;
    do_reset();
    start_run(16'd1);
    wait_start(20, got, is_bp);
    @(negedge clk);
    bp_valid = 1'b1;
    run = 1'b1;
    epochs = 16'd0;
    @(negedge clk);
    bp_valid = 1'b0;
    run = 1'b0;
    s0 = fwd_starts + bp_starts;
    d0 = dones;
    repeat (5) @(negedge clk);
    vectors++;
    if (fwd_starts + bp_starts - s0 !== 0 || dones - d0 !== 0 || busy !== 1'b1 || fwd_layer !== 2'd0) begin
      $display("[TB] FAIL stray_ignored: got starts %0d dones %0d busy %b layer %0d expected 0 0 1 0",
               fwd_starts + bp_starts - s0, dones - d0, busy, fwd_layer);
      miscompares++;
    end
    pulse_valid(0, 1'b0);
    wait_start(20, got, is_bp);
    vectors++;
    if (!got || is_bp !== 1'b0 || fwd_layer !== 2'd1) begin
      $display("[TB] FAIL stray_resume: got start %0d bp %0d layer %0d expected 1 0 1", got, is_bp, fwd_layer);
      miscompares++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pulse_valid(1, 1'b0);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      $display("[TB] FAIL stray_finish: got busy %b expected 0", busy);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    bit got, is_bp;
    int d0;
    do_reset();
    start_run(16'd1);
    wait_start(20, got, is_bp);
    d0 = dones;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (dones - d0 !== 0 || {busy, fault} !== 2'b00 || fwd_layer !== 2'd0) begin
      $display("[TB] FAIL reset_mid: got dones %0d busy/fault %b layer %0d expected 0 00 0",
               dones - d0, {busy, fault}, fwd_layer);
      miscompares++;
    end
  endtask

  task automatic test_watchdog();
    bit got, is_bp;
    do_reset();
    start_run(16'd1);
    wait_start(20, got, is_bp);
`ifdef TRAIN_WATCHDOG_EN
    repeat (15) @(negedge clk);
    vectors++;
    if (fault !== 1'b0) begin
      $display("[TB] FAIL wd_early: got fault %b expected 0", fault);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({fault, busy} !== 2'b10) begin
      $display("[TB] FAIL wd_fault: got fault/busy %b expected 10", {fault, busy});
      miscompares++;
    end
`else
    repeat (40) @(negedge clk);
    vectors++;
    if ({fault, busy} !== 2'b01) begin
      $display("[TB] FAIL wait_forever: got fault/busy %b expected 01", {fault, busy});
      miscompares++;
    end
`endif
    do_reset();
  endtask

  initial begin
    $display("[TB] training_sequencer bench starting");
    test_reset();
    test_full_epoch();
    test_zero_epochs();
    test_bp_error();
    test_abort();
    test_stray();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
